// File: rtl/adder_share_arbiter_if.sv
// adder_share_arbiter_if: request, shared-adder and response signals of the adder-sharing arbiter
interface adder_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
);
  logic [N_REQ-1:0]    req_valid;
  logic [12*N_REQ-1:0] req_a;
  logic [12*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    req_ready;
  logic [11:0]         adder_a;
  logic [11:0]         adder_b;
  logic [11:0]         adder_sum;
  logic                adder_ovf;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [11:0]         rsp_sum;
  logic                rsp_ovf;
  logic [CNT_W-1:0]    op_count;

  modport slave (
    input  req_valid, req_a, req_b, adder_sum, adder_ovf, rsp_ready,
    output req_ready, adder_a, adder_b, rsp_valid, rsp_id, rsp_sum, rsp_ovf, op_count
  );

  modport master (
    output req_valid, req_a, req_b, adder_sum, adder_ovf, rsp_ready,
    input  req_ready, adder_a, adder_b, rsp_valid, rsp_id, rsp_sum, rsp_ovf, op_count
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one 12-bit adder with a one-entry tagged response register
module adder_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input logic clock,
  input logic reset,
  adder_share_arbiter_if.slave bus
);
  logic [ID_W-1:0]    rr_ptr;
  logic [2*N_REQ-1:0] rot;
  logic               found;
  logic [ID_W-1:0]    off;
  logic [ID_W:0]      pos;
  logic [ID_W-1:0]    win;
  logic               can_issue;
  logic               grant;

  assign rot       = {bus.req_valid, bus.req_valid} >> rr_ptr;
  assign pos       = {1'b0, rr_ptr} + {1'b0, off};
  assign win       = pos >= (ID_W+1)'(N_REQ) ? ID_W'(pos - (ID_W+1)'(N_REQ)) : pos[ID_W-1:0];
  assign can_issue = !bus.rsp_valid | bus.rsp_ready;
  assign grant     = found & can_issue & !reset;
  assign bus.req_ready = grant ? {{(N_REQ-1){1'b0}}, 1'b1} << win : '0;
  assign bus.adder_a   = found ? 12'(bus.req_a >> (12 * win)) : '0;
  assign bus.adder_b   = found ? 12'(bus.req_b >> (12 * win)) : '0;

  // lowest set bit of the request vector rotated to start at rr_ptr is the winner's offset
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = ID_W'(k);
      end
    end
  end

  // response register, round-robin pointer and accepted-response counter
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_sum   <= '0;
      bus.rsp_ovf   <= 1'b0;
      bus.op_count  <= '0;
      rr_ptr        <= '0;
    end else begin
      if (grant) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_id    <= win;
        bus.rsp_sum   <= bus.adder_sum;
        bus.rsp_ovf   <= bus.adder_ovf;
        rr_ptr        <= win == ID_W'(N_REQ - 1) ? '0 : win + 1'b1;
      end else if (bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
      end
      if (bus.rsp_valid & bus.rsp_ready) bus.op_count <= bus.op_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed-vector check of arbitration, backpressure and reset
module tb_adder_share_arbiter;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;

  adder_share_arbiter_if #(.N_REQ(4), .ID_W(2), .CNT_W(16)) bus ();

  adder_share_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(16)) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus.slave)
  );

  assign {bus.adder_ovf, bus.adder_sum} = {1'b0, bus.adder_a} + {1'b0, bus.adder_b};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [11:0] a, input logic [11:0] b);
    bus.req_a[12*i +: 12] = a;
    bus.req_b[12*i +: 12] = b;
  endtask

  task automatic check_rsp(input string tag, input logic [1:0] id, input logic [11:0] sum, input logic ovf);
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
    check({tag, "_sum"}, 32'(bus.rsp_sum), 32'(sum));
    check({tag, "_ovf"}, 32'(bus.rsp_ovf), 32'(ovf));
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_cnt", 32'(bus.op_count), 32'h0);
    check("rst_sum", 32'(bus.rsp_sum), 32'h0);
    rst = 1'b0;
    bus.req_valid = 4'b0000;
    @(negedge clk);
    // single request
    set_op(0, 12'h7FF, 12'h001);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b1;
    #1 check("single_ready", 32'(bus.req_ready), 32'h1);
    check("single_adder_a", 32'(bus.adder_a), 32'h7FF);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    check_rsp("single", 2'd0, 12'h800, 1'b0);
    check("single_cnt0", 32'(bus.op_count), 32'd0);
    @(negedge clk);
    check("single_cnt1", 32'(bus.op_count), 32'd1);
    check("single_drain", 32'(bus.rsp_valid), 32'd0);
    // carry-out, rr_ptr=1 so requester 2 wins
    set_op(2, 12'hFFF, 12'h001);
    bus.req_valid = 4'b0100;
    #1 check("carry_ready", 32'(bus.req_ready), 32'h4);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    check_rsp("carry", 2'd2, 12'h000, 1'b1);
    @(negedge clk);
    check("carry_cnt", 32'(bus.op_count), 32'd2);
    // fresh reset so round-robin starts at 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, 12'(32'h100 * (i + 1)), 12'(i + 1));
    bus.req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #1 check("rr_grant", 32'(bus.req_ready), 32'd1 << (k % 4));
      if (k > 0) begin
        check("rr_id", 32'(bus.rsp_id), 32'((k - 1) % 4));
        check("rr_sum", 32'(bus.rsp_sum), 32'h101 * ((k - 1) % 4 + 1));
      end
      @(negedge clk);
    end
    bus.req_valid = 4'b0000;
    check_rsp("rr_last", 2'd1, 12'h202, 1'b0);
    check("rr_cnt5", 32'(bus.op_count), 32'd5);
    @(negedge clk);
    check("rr_cnt6", 32'(bus.op_count), 32'd6);
    // backpressure: rr_ptr=2, requester 3 fills the register, then stall
    set_op(3, 12'h123, 12'h456);
    bus.req_valid = 4'b1000;
    bus.rsp_ready = 1'b0;
    #1 check("bp_fill_ready", 32'(bus.req_ready), 32'h8);
    @(negedge clk);
    set_op(1, 12'h0AA, 12'h055);
    set_op(2, 12'h800, 12'h800);
    bus.req_valid = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_stall_ready", 32'(bus.req_ready), 32'h0);
      check_rsp("bp_hold", 2'd3, 12'h579, 1'b0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1 check("bp_release_ready", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    check_rsp("bp_replace", 2'd1, 12'h0FF, 1'b0);
    check("bp_cnt7", 32'(bus.op_count), 32'd7);
    @(negedge clk);
    check("bp_cnt8", 32'(bus.op_count), 32'd8);
    check("bp_empty", 32'(bus.rsp_valid), 32'd0);
    // pointer skip: grant 0 to move rr_ptr to 1, then only requester 3
    set_op(0, 12'h010, 12'h020);
    bus.req_valid = 4'b0001;
    #1 check("skip_r0", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = 4'b1000;
    #1 check("skip_r3", 32'(bus.req_ready), 32'h8);
    check_rsp("skip_rsp0", 2'd0, 12'h030, 1'b0);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    check_rsp("skip_rsp3", 2'd3, 12'h579, 1'b0);
    repeat (3) @(negedge clk);
    check("skip_cnt", 32'(bus.op_count), 32'd10);
    // rr_ptr held at 0 across idle cycles
    bus.req_valid = 4'b0011;
    bus.rsp_ready = 1'b0;
    #1 check("hold_ptr", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = 4'b0110;
    check_rsp("mid_pending", 2'd0, 12'h030, 1'b0);
    // reset mid-operation drops the pending response uncounted
    rst = 1'b1;
    #1 check("mid_rst_ready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_cnt", 32'(bus.op_count), 32'd0);
    check("mid_sum", 32'(bus.rsp_sum), 32'd0);
    #1 check("mid_lowest", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    check_rsp("mid_after", 2'd1, 12'h0FF, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
